// File: rtl/dht11_pkg.sv
// Shared types and default protocol timing for the DHT11 responder.
// All durations are expressed in 10 us ticks.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_LOW = 3'd1,
    ST_RESP_WAIT = 3'd2,
    ST_RESP_LOW  = 3'd3,
    ST_RESP_HIGH = 3'd4,
    ST_BIT_LOW   = 3'd5,
    ST_BIT_HIGH  = 3'd6,
    ST_END_LOW   = 3'd7
  } dht_state_e;

  localparam int FRAME_W       = 40;
  localparam int DEF_START_MIN = 1800;
  localparam int DEF_RESP_DLY  = 3;
  localparam int DEF_PRE_LOW   = 8;
  localparam int DEF_PRE_HIGH  = 8;
  localparam int DEF_BIT_LOW   = 5;
  localparam int DEF_BIT0_HIGH = 3;
  localparam int DEF_BIT1_HIGH = 7;
  localparam int DEF_END_LOW   = 5;

  // Modulo-256 sum of the four payload bytes, optionally inverted for fault injection.
  function automatic logic [7:0] dht_csum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d,
                                          input logic inv);
    logic [7:0] s;
    s = a + b + c + d;
    return inv ? ~s : s;
  endfunction

endpackage

// File: rtl/dht11_tick_cnt.sv
// Free-running tick divider: pulses o_tick for one clk every DIV cycles.
// i_clr restarts the count so a new phase always begins on a whole tick.
module dht11_tick_cnt #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign o_tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (i_clr || o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: waits for the host start pulse, sends the response
// preamble and then the 40-bit frame MSB first on an open-drain line.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int SYS_CLK   = 100_000_000,
  parameter int TICK_FREQ = 100_000,
  parameter int START_MIN = DEF_START_MIN,
  parameter int RESP_DLY  = DEF_RESP_DLY,
  parameter int PRE_LOW   = DEF_PRE_LOW,
  parameter int PRE_HIGH  = DEF_PRE_HIGH,
  parameter int BIT_LOW   = DEF_BIT_LOW,
  parameter int BIT0_HIGH = DEF_BIT0_HIGH,
  parameter int BIT1_HIGH = DEF_BIT1_HIGH,
  parameter int END_LOW   = DEF_END_LOW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_bus,
  output logic       o_bus_oe,
  input  logic [7:0] i_humid_int,
  input  logic [7:0] i_humid_dec,
  input  logic [7:0] i_temp_int,
  input  logic [7:0] i_temp_dec,
  input  logic       i_csum_err,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_state
);

  localparam int TICK_DIV = SYS_CLK / TICK_FREQ;

  dht_state_e         state, state_nxt;
  logic [1:0]         sync_q;
  logic               bus_s;
  logic               tick, tick_clr;
  logic [10:0]        phase_cnt, phase_len;
  logic               phase_end;
  logic [5:0]         bit_idx;
  logic [FRAME_W-1:0] shreg;

  assign bus_s   = sync_q[1];
  assign o_state = state;

  // In IDLE the divider is parked while the line is high; the detection cycle
  // itself is allowed to count so START_LOW measures the full host-low time.
  assign tick_clr = (state == ST_IDLE) ? bus_s : (state_nxt != state);

  dht11_tick_cnt #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (tick_clr),
    .o_tick (tick)
  );

  always_comb begin
    phase_len = 11'd1;
    case (state)
      ST_RESP_WAIT: phase_len = 11'(RESP_DLY);
      ST_RESP_LOW:  phase_len = 11'(PRE_LOW);
      ST_RESP_HIGH: phase_len = 11'(PRE_HIGH);
      ST_BIT_LOW:   phase_len = 11'(BIT_LOW);
      ST_BIT_HIGH:  phase_len = shreg[FRAME_W-1] ? 11'(BIT1_HIGH) : 11'(BIT0_HIGH);
      ST_END_LOW:   phase_len = 11'(END_LOW);
      default:      phase_len = 11'd1;
    endcase
  end

  assign phase_end = tick && (phase_cnt == phase_len - 11'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!bus_s) state_nxt = ST_START_LOW;
      ST_START_LOW: if (bus_s) state_nxt = (phase_cnt >= 11'(START_MIN)) ? ST_RESP_WAIT : ST_IDLE;
      ST_RESP_WAIT: if (phase_end) state_nxt = ST_RESP_LOW;
      ST_RESP_LOW:  if (phase_end) state_nxt = ST_RESP_HIGH;
      ST_RESP_HIGH: if (phase_end) state_nxt = ST_BIT_LOW;
      ST_BIT_LOW:   if (phase_end) state_nxt = ST_BIT_HIGH;
      ST_BIT_HIGH:  if (phase_end) state_nxt = (bit_idx == 6'd0) ? ST_END_LOW : ST_BIT_LOW;
      ST_END_LOW:   if (phase_end) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      state     <= ST_IDLE;
      phase_cnt <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      o_bus_oe  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_bus};
      state  <= state_nxt;

      if (state_nxt != state) begin
        phase_cnt <= '0;
      end else if (tick && (phase_cnt != '1)) begin
        phase_cnt <= phase_cnt + 11'd1;
      end

      // Payload is frozen at start acceptance; later input changes are ignored.
      if (state == ST_START_LOW && state_nxt == ST_RESP_WAIT) begin
        shreg <= {i_humid_int, i_humid_dec, i_temp_int, i_temp_dec,
                  dht_csum(i_humid_int, i_humid_dec, i_temp_int, i_temp_dec, i_csum_err)};
      end
      if (state == ST_RESP_HIGH && state_nxt == ST_BIT_LOW) begin
        bit_idx <= 6'(FRAME_W - 1);
      end
      if (state == ST_BIT_HIGH && state_nxt == ST_BIT_LOW) begin
        shreg   <= shreg << 1;
        bit_idx <= bit_idx - 6'd1;
      end

      o_bus_oe <= (state_nxt == ST_RESP_LOW) || (state_nxt == ST_BIT_LOW) ||
                  (state_nxt == ST_END_LOW);
      o_busy   <= !((state_nxt == ST_IDLE) || (state_nxt == ST_START_LOW));
      o_done   <= (state == ST_END_LOW) && (state_nxt == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: host start pulses, waveform-level frame model,
// reset and snapshot scenarios. Start threshold is shortened to keep runs brief.
module tb_dht11_responder;

  localparam int SYS_CLK     = 100_000_000;
  localparam int TICK_FREQ   = 10_000_000;
  localparam int DIV         = SYS_CLK / TICK_FREQ;
  localparam int START_MIN_T = 50;
  localparam int T_RESP_DLY  = 3;
  localparam int T_PRE_LOW   = 8;
  localparam int T_PRE_HIGH  = 8;
  localparam int T_BIT_LOW   = 5;
  localparam int T_BIT0      = 3;
  localparam int T_BIT1      = 7;
  localparam int T_END_LOW   = 5;
  localparam int SYNC_LAT    = 2;
  localparam int N_EDGES     = 4 + 2 * 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_lvl = 1'b1;
  logic       i_bus;
  logic       o_bus_oe, o_busy, o_done;
  logic [2:0] o_state;
  logic [7:0] humid_int = 8'h00, humid_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
  logic       csum_err = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int   oe_edges[$];
  int   done_cyc[$];
  logic prev_oe = 1'b0;
  bit   busy_seen = 1'b0;

  // Open-drain line: low whenever either the host or the responder pulls it.
  assign i_bus = host_lvl & ~o_bus_oe;

  dht11_responder #(
    .SYS_CLK   (SYS_CLK),
    .TICK_FREQ (TICK_FREQ),
    .START_MIN (START_MIN_T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_bus       (i_bus),
    .o_bus_oe    (o_bus_oe),
    .i_humid_int (humid_int),
    .i_humid_dec (humid_dec),
    .i_temp_int  (temp_int),
    .i_temp_dec  (temp_dec),
    .i_csum_err  (csum_err),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_state     (o_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Line monitor: cycle index of every oe edge and every done pulse.
  always @(negedge clk) begin
    if (o_bus_oe !== prev_oe) begin
      oe_edges.push_back(cyc);
      prev_oe = o_bus_oe;
    end
    if (o_done === 1'b1) done_cyc.push_back(cyc);
    if (o_busy === 1'b1) busy_seen = 1'b1;
  end

  function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d,
                                              input logic err);
    int sum;
    sum = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
    if (err) sum = 255 - sum;
    return {a, b, c, d, sum[7:0]};
  endfunction

  task automatic clear_mon();
    oe_edges.delete();
    done_cyc.delete();
    busy_seen = 1'b0;
  endtask

  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic err);
    @(negedge clk);
    humid_int = a; humid_dec = b; temp_int = c; temp_dec = d; csum_err = err;
  endtask

  // Host start pulse of 'ticks' ticks; rel is the posedge that first sees the release.
  task automatic host_start(input int ticks, output int rel, output logic [2:0] mid_state);
    @(negedge clk);
    host_lvl = 1'b0;
    mid_state = 3'bxxx;
    for (int i = 0; i < ticks * DIV; i++) begin
      @(negedge clk);
      if (i == (ticks * DIV) / 2) mid_state = o_state;
    end
    host_lvl = 1'b1;
    rel = cyc + 1;
  endtask

  task automatic check_frame(input int rel, input logic [39:0] exp_frame, input string name);
    logic [31:0] exp_q[$];
    int          t, waited, bad;
    logic [39:0] got;
    waited = 0;
    while (done_cyc.size() == 0 && waited < 8000) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    checks++;
    if (done_cyc.size() == 0) begin
      failures++;
      $display("FAIL %s done_timeout: no o_done after %0d cycles, expected one pulse", name, waited);
      return;
    end
    t = rel + SYNC_LAT + T_RESP_DLY * DIV;
    exp_q.push_back(t); t += T_PRE_LOW * DIV;
    exp_q.push_back(t); t += T_PRE_HIGH * DIV;
    for (int j = 0; j < 40; j++) begin
      exp_q.push_back(t); t += T_BIT_LOW * DIV;
      exp_q.push_back(t); t += (exp_frame[39 - j] ? T_BIT1 : T_BIT0) * DIV;
    end
    exp_q.push_back(t); t += T_END_LOW * DIV;
    exp_q.push_back(t);

    checks++;
    if (oe_edges.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s edge_count: got %0d oe edges, expected %0d", name, oe_edges.size(), exp_q.size());
    end
    bad = -1;
    for (int k = 0; k < exp_q.size() && k < oe_edges.size(); k++)
      if (bad < 0 && oe_edges[k] != int'(exp_q[k])) bad = k;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s edge_time: edge %0d at cycle %0d, expected cycle %0d", name, bad, oe_edges[bad], exp_q[bad]);
    end
    got = 'x;
    if (oe_edges.size() >= N_EDGES - 1)
      for (int j = 0; j < 40; j++)
        got[39 - j] = (oe_edges[4 + 2 * j] - oe_edges[3 + 2 * j]) > 5 * DIV;
    checks++;
    if (got !== exp_frame) begin
      failures++;
      $display("FAIL %s frame_bits: decoded %h, expected %h", name, got, exp_frame);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != t) begin
      failures++;
      $display("FAIL %s done_pulse: %0d pulses first at cycle %0d, expected 1 at cycle %0d",
               name, done_cyc.size(), done_cyc[0], t);
    end
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic err, input string name);
    int rel;
    logic [2:0] ms;
    clear_mon();
    set_bytes(a, b, c, d, err);
    host_start(START_MIN_T, rel, ms);
    check_frame(rel, model_frame(a, b, c, d, err), name);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (o_bus_oe !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: oe=%b busy=%b done=%b state=%0d, expected 0 0 0 0",
               o_bus_oe, o_busy, o_done, o_state);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int rel;
    logic [2:0] ms;
    clear_mon();
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
    host_start(START_MIN_T, rel, ms);
    checks++;
    if (ms !== 3'd1) begin
      failures++;
      $display("FAIL basic_start_state: state %0d during host low, expected 1", ms);
    end
    check_frame(rel, 40'h37_00_19_05_55, "basic");
    repeat (20) @(negedge clk);
  endtask

  task automatic test_short_start();
    int rel;
    logic [2:0] ms;
    clear_mon();
    host_start(START_MIN_T - 1, rel, ms);
    repeat (300) @(negedge clk);
    checks++;
    if (oe_edges.size() != 0 || busy_seen || done_cyc.size() != 0 || o_state !== 3'd0) begin
      failures++;
      $display("FAIL short_start: oe_edges=%0d busy_seen=%0d dones=%0d state=%0d, expected 0 0 0 0",
               oe_edges.size(), busy_seen, done_cyc.size(), o_state);
    end
  endtask

  task automatic test_extremes();
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, "all_ones");
    run_frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "all_zeros");
  endtask

  task automatic test_csum_err();
    logic [39:0] f;
    f = model_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    checks++;
    if (f[7:0] !== 8'hF5) begin
      failures++;
      $display("FAIL csum_model: model checksum %h, expected f5", f[7:0]);
    end
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, "csum_err");
  endtask

  task automatic test_reset_mid();
    int rel, waited;
    logic [2:0] ms;
    clear_mon();
    set_bytes(8'($urandom_range(0, 255)), 8'h5A, 8'hC3, 8'($urandom_range(0, 255)), 1'b0);
    host_start(START_MIN_T, rel, ms);
    waited = 0;
    while (oe_edges.size() < 41 && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (oe_edges.size() < 41) begin
      failures++;
      $display("FAIL reset_mid_reach: %0d oe edges, expected at least 41", oe_edges.size());
    end
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_bus_oe !== 1'b0 || o_state !== 3'd0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: oe=%b state=%0d busy=%b, expected 0 0 0", o_bus_oe, o_state, o_busy);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, "after_reset");
  endtask

  task automatic test_input_change();
    int rel;
    logic [2:0] ms;
    logic [39:0] f;
    clear_mon();
    set_bytes(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    f = model_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    host_start(START_MIN_T, rel, ms);
    repeat (20) @(negedge clk);
    humid_int = 8'hAA; humid_dec = 8'hAA; temp_int = 8'hAA; temp_dec = 8'hAA; csum_err = 1'b1;
    check_frame(rel, f, "input_change");
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++)
      run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), $sformatf("random%0d", n));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_frame();
    test_short_start();
    test_extremes();
    test_csum_err();
    test_reset_mid();
    test_input_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
- Synthesizable DHT11 sensor emulator: the responder end of the single-wire DHT11 protocol whose host side the DHT11 controller drives.
- Detects the host start pulse, answers with the DHT11 response preamble, then serializes 40 bits: humid_int, humid_dec, temp_int, temp_dec, checksum, MSB first.
- Used as an on-board loopback target and as the bench model for controller verification.
- All timing is quantized to an internal 10 us tick.

Parameters:
- SYS_CLK, 100_000_000, system clock frequency in Hz.
- TICK_FREQ, 100_000, tick rate in Hz (10 us). Benches override it to shorten simulation.
- START_MIN, 1800, minimum host-low ticks accepted as a start (18 ms).
- RESP_DLY, 3, ticks between host release and the responder pulling low.
- PRE_LOW, 8, response low ticks.
- PRE_HIGH, 8, response released ticks.
- BIT_LOW, 5, per-bit low ticks.
- BIT0_HIGH, 3, released ticks for a '0'.
- BIT1_HIGH, 7, released ticks for a '1'.
- END_LOW, 5, trailing low ticks after bit 39.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- i_bus  in  1  sampled level of the DHT11 data line (asynchronous)
- o_bus_oe  out  1  1 = pull line low (open-drain), 0 = release
- i_humid_int  in  8  humidity integer byte
- i_humid_dec  in  8  humidity decimal byte
- i_temp_int  in  8  temperature integer byte
- i_temp_dec  in  8  temperature decimal byte
- i_csum_err  in  1  1 = transmit inverted checksum (fault injection)
- o_busy  out  1  high outside IDLE/START_LOW
- o_done  out  1  one-cycle pulse when END_LOW completes
- o_state  out  3  current state encoding (debug)

Behaviour:
- Reset (rst=0 at a posedge):
  - Next state is IDLE; o_bus_oe=0, o_busy=0, o_done=0, o_state=0.
  - All counters and shift register clear, sync FFs load 1.
  - Reset mid-frame releases the bus on that same edge.
- i_bus passes through a 2-FF synchronizer (2-cycle latency). All edge and level decisions use the synchronized value.
- Tick sub-counter:
  - Wraps at SYS_CLK/TICK_FREQ-1 and pulses tick for 1 cycle.
  - Cleared on every state transition, so each phase lasts exactly N*(SYS_CLK/TICK_FREQ) cycles.
- Phase tick counter: 11 bits, saturating, cleared on state transition.
- States:
  - IDLE: bus low → START_LOW.
  - START_LOW: count ticks while low. On bus high:
    - if count ≥ START_MIN → RESP_WAIT; snapshot the four data bytes.
    - else → IDLE (glitch or short pulse ignored).
  - RESP_WAIT: after RESP_DLY ticks → RESP_LOW.
  - RESP_LOW: oe=1 for PRE_LOW ticks → RESP_HIGH.
  - RESP_HIGH: oe=0 for PRE_HIGH ticks → BIT_LOW, with bit index=39.
  - BIT_LOW: oe=1 for BIT_LOW ticks → BIT_HIGH.
  - BIT_HIGH: oe=0 for BIT0_HIGH or BIT1_HIGH ticks, chosen by shreg[39]. Then:
    - if index==0 → END_LOW;
    - else shift left and decrement index → BIT_LOW.
  - END_LOW: oe=1 for END_LOW ticks, then oe=0, o_done=1 for 1 cycle → IDLE.
- o_bus_oe is registered: it changes on the edge that enters or leaves a driving state.
- Checksum is the 8-bit modulo-256 sum of the four snapshot bytes, inverted when i_csum_err=1 (sampled at snapshot).
- Input bytes changing mid-frame have no effect.
- While transmitting, i_bus is ignored: no collision detection. A new start is only recognized from IDLE.
- Unmapped state encoding → IDLE.

Decomposition:
- Package dht11_pkg:
  - state enum (IDLE=0, START_LOW=1, RESP_WAIT=2, RESP_LOW=3, RESP_HIGH=4, BIT_LOW=5, BIT_HIGH=6, END_LOW=7);
  - default timing constants;
  - frame width 40.
- One sub-module: dht11_tick_cnt (clk, rst, i_clr, o_tick) with the same reset rule.

Test Plan (TICK_FREQ=10_000_000, tick = 10 clk):
- Host pulls low 1800 ticks, releases; bytes 0x37,0x00,0x19,0x05:
  - oe rises 3 ticks after release, low 8 ticks, released 8 ticks;
  - decoded 40 bits = 0x37_00_19_05_55;
  - o_done pulses once; the start-detect to release latency includes the 2-cycle sync.
- Host low 1799 ticks → no oe activity, o_busy stays 0, state returns to IDLE.
- All bytes 0xFF → checksum 0xFC; every bit high phase = 70 clk. All bytes 0x00 → every high phase = 30 clk.
- i_csum_err=1 with bytes 0x01,0x02,0x03,0x04 → checksum byte 0xF5.
- Assert rst=0 during bit 20 low phase → oe=0 on that edge, state IDLE. After release, a fresh start produces a complete correct frame.
- Change inputs to 0xAA after snapshot → transmitted frame still carries the snapshot values.
